mips_stage_mem_multicycle: RTL and testbench
============================================

# mips_stage_mem_multicycle

Parametrised MIPS memory stage sitting between the ExMem and MemReg pipeline registers. It succeeds the single-cycle memory stage. It adds:
- a configurable data-memory latency, with a stall output that freezes upstream stages;
- byte/halfword/word access sizes with sign/zero extension;
- per-byte write enables;
- a valid bit that travels with each instruction.

Non-memory instructions pass through with one cycle of latency and never stall.

## Interface
Parameters:
- ADDR_L, 64, data memory depth in 32-bit words.
- ADDR_W, Util_Math_log2(ADDR_L), word-index width.
- MEM_LATENCY, 1, cycles from acceptance of a load/store to its MemReg output; legal range 1..8.
- DELAYED, 1, 1 = MemReg outputs registered; 0 = combinational pass-through, legal only with MEM_LATENCY=1.

Ports:
- ctrl.clock  input  1  rising-edge clock, carried in the ctrl bundle.
- ctrl.reset  input  1  synchronous, active-high reset, carried in the ctrl bundle.
- pipeExMem  input  Mips_Pipeline_ExMem_T  instruction, pcAddr, control, regPort2, aluResult. Uses control.memRead, control.memWrite, control.memSize (2b: 0 byte, 1 half, 2 word), control.memSigned.
- exMemValid  input  1  pipeExMem holds a real instruction.
- memStall  output  1  upstream must hold ExMem contents and not advance.
- pipeMemReg  output  Mips_Pipeline_MemReg_T  instruction, pcAddr, memOut, aluResult, control.
- memRegValid  output  1  pipeMemReg holds a completed instruction.
- memFault  output  1  misaligned access flagged; only meaningful with the configuration macro.

## Operation
- Word index is aluResult[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*ADDR_L bytes.
- State machine:
  - IDLE: on exMemValid, the block accepts the instruction and latches the ExMem fields internally.
  - If the instruction is a memory op and MEM_LATENCY>1, go to BUSY with counter=MEM_LATENCY-2. Otherwise complete this cycle.
  - BUSY: decrement the counter each cycle. When counter==0, complete and return to IDLE.
- memStall = (IDLE and exMemValid and memory op and MEM_LATENCY>1) or (BUSY and counter!=0).
- Completion:
  - A store writes only on the completion edge, exactly once.
  - Byte enables come from memSize and aluResult[1:0]. Store data is regPort2[7:0] or [15:0], replicated into the selected lane.
  - A load selects its lane from the word read. It is sign-extended if memSigned=1, else zero-extended. A word load returns the full word.
- memOut = 0 for non-load instructions.
- If memRead and memWrite are both set, the instruction is treated as a store and memOut=0.
- An invalid input (exMemValid=0) in IDLE produces a bubble (memRegValid=0). The memory is never written.

## Timing
- Memory op accepted in cycle T:
  - memStall is high for cycles T..T+MEM_LATENCY-2.
  - It is low in cycle T+MEM_LATENCY-1, so upstream advances at the end of that cycle.
  - pipeMemReg/memRegValid are valid in cycle T+MEM_LATENCY, for one cycle.
- Non-memory op accepted in T: output is valid in T+1, memStall stays low.
- Back-to-back instructions: a new instruction can be accepted in cycle T+MEM_LATENCY, so sustained throughput is 1 per MEM_LATENCY cycles for memory ops and 1 per cycle otherwise.
- Read-after-write: a load to an address is accepted after a store to it has completed, so the load returns the stored data.
- Reset values:
  - state IDLE, counter 0;
  - memStall 0, memRegValid 0, memFault 0;
  - pipeMemReg all-zero.
  - Reset in BUSY aborts the operation: the pending store is not written and no output is produced.
  - Memory contents are not cleared by reset.
- Reset takes priority over simultaneous exMemValid.

## Configuration
- MIPS_STAGE_MEM_ALIGN_CHECK_EN defined: a misaligned access sets memFault with memRegValid at completion. Misaligned means a half with aluResult[0]=1 or a word with aluResult[1:0]!=0. Such an access:
  - suppresses the store;
  - forces memOut=0;
  - clears control.regWrite in pipeMemReg.
  - Stall timing is unchanged.
- Undefined: memFault is tied to 0. Misaligned low bits are masked (a half uses aluResult[1], a word ignores [1:0]), and the access proceeds normally.

## Test plan
- MEM_LATENCY=1, store word 0xDEADBEEF to 0x10, then load word from 0x10 -> memOut=0xDEADBEEF one cycle after the load; memStall never asserts.
- MEM_LATENCY=3:
  - Load accepted at T -> memStall high in T, T+1 and low in T+2; memRegValid high only in T+3.
  - A following ALU op (add) outputs at T+4.
- Store byte 0x80 to 0x21, then load byte signed/unsigned from 0x21 -> 0xFFFFFF80 / 0x00000080. Other bytes of word 0x20 are unchanged.
- MEM_LATENCY=4, assert reset in the second BUSY cycle of a store to 0x08 -> outputs are zero next cycle, and a later load of 0x08 returns its prior value.
- Address wrap: ADDR_L=64, store word to 0x104 -> a load from 0x004 returns that data.
- Macro defined: load half from 0x13 -> memFault=1, memOut=0, regWrite=0. Macro undefined: same load returns the half at 0x12.

Source files
------------

// File: rtl/mips_stage_mem_multicycle_if.sv
// Pipeline bundle types and the ExMem -> MemReg handshake interface
// for the multicycle MIPS memory stage.
package mips_stage_mem_pkg;

    typedef struct packed {
        logic       regWrite;
        logic       memToReg;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memSize;
        logic       memSigned;
    } Mips_Control_T;

    typedef struct packed {
        logic [31:0]   instruction;
        logic [31:0]   pcAddr;
        Mips_Control_T control;
        logic [31:0]   regPort2;
        logic [31:0]   aluResult;
    } Mips_Pipeline_ExMem_T;

    typedef struct packed {
        logic [31:0]   instruction;
        logic [31:0]   pcAddr;
        logic [31:0]   memOut;
        logic [31:0]   aluResult;
        Mips_Control_T control;
    } Mips_Pipeline_MemReg_T;

endpackage

interface mips_stage_mem_multicycle_if;
    import mips_stage_mem_pkg::*;

    Mips_Pipeline_ExMem_T  pipeExMem;
    logic                  exMemValid;
    logic                  memStall;
    Mips_Pipeline_MemReg_T pipeMemReg;
    logic                  memRegValid;
    logic                  memFault;

    modport master (
        output pipeExMem, exMemValid,
        input  memStall, pipeMemReg, memRegValid, memFault
    );

    modport slave (
        input  pipeExMem, exMemValid,
        output memStall, pipeMemReg, memRegValid, memFault
    );

endinterface

// File: rtl/mips_stage_mem_multicycle.sv
// Multicycle MIPS memory stage: variable latency, byte/half/word access.
// Define MIPS_STAGE_MEM_ALIGN_CHECK_EN to fault misaligned accesses.
module mips_stage_mem_multicycle #(
    parameter int ADDR_L      = 64,
    parameter int ADDR_W      = $clog2(ADDR_L),
    parameter int MEM_LATENCY = 1,
    parameter bit DELAYED     = 1'b1
) (
    input logic                         clock,
    input logic                         reset,
    mips_stage_mem_multicycle_if.slave  mem_if
);
    import mips_stage_mem_pkg::*;

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] CNT_INIT =
        3'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);
    localparam logic MULTI = (MEM_LATENCY > 1);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    Mips_Pipeline_ExMem_T  hold_q, hold_d;
    Mips_Pipeline_MemReg_T out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    logic [31:0] mem_q [ADDR_L];

    Mips_Pipeline_ExMem_T op;
    logic              is_mem, is_store, is_load;
    logic              stall, complete, fault, we;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lo;
    logic [3:0]        be;
    logic [31:0]       rword, wdata, load_val;
    logic [7:0]        lb;
    logic [15:0]       lh;

    // Select the live instruction and decide stall / completion
    always_comb begin
        op       = (state_q == BUSY) ? hold_q : mem_if.pipeExMem;
        is_store = op.control.memWrite;
        is_load  = op.control.memRead & ~op.control.memWrite;
        is_mem   = op.control.memRead | op.control.memWrite;
        stall    = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall    = mem_if.exMemValid & is_mem & MULTI;
                complete = mem_if.exMemValid & ~(is_mem & MULTI);
            end
            BUSY: begin
                stall    = (cnt_q != 3'd0);
                complete = (cnt_q == 3'd0);
            end
            default: ;
        endcase
    end

    // Byte lanes, store data, load extraction and fault detection
    always_comb begin
        idx      = op.aluResult[ADDR_W+1:2];
        lo       = op.aluResult[1:0];
        rword    = mem_q[idx];
        be       = 4'b1111;
        wdata    = op.regPort2;
        load_val = rword;
        lb       = rword[{lo, 3'b000} +: 8];
        lh       = lo[1] ? rword[31:16] : rword[15:0];
        unique case (op.control.memSize)
            2'd0: begin
                be       = 4'b0001 << lo;
                wdata    = {4{op.regPort2[7:0]}};
                load_val = {{24{op.control.memSigned & lb[7]}}, lb};
            end
            2'd1: begin
                be       = lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{op.regPort2[15:0]}};
                load_val = {{16{op.control.memSigned & lh[15]}}, lh};
            end
            default: ;
        endcase
`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
        fault = is_mem & (
            (op.control.memSize == 2'd1) ? lo[0] :
            op.control.memSize[1]        ? (lo != 2'd0) :
                                           1'b0);
`else
        fault = 1'b0;
`endif
        we = complete & is_store & ~fault & ~reset;
    end

    // Build MemReg result and next FSM state
    always_comb begin
        out_d   = '0;
        valid_d = complete & ~reset;
        fault_d = complete & fault & ~reset;
        if (complete) begin
            out_d.instruction = op.instruction;
            out_d.pcAddr      = op.pcAddr;
            out_d.aluResult   = op.aluResult;
            out_d.control     = op.control;
            out_d.memOut      = (is_load & ~fault) ? load_val : 32'd0;
            if (fault) begin
                out_d.control.regWrite = 1'b0;
            end
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (stall) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    hold_d  = mem_if.pipeExMem;
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and MemReg registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Data memory: per-byte writes on completion, contents survive reset
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_if.memStall = stall;

    generate
        if (DELAYED) begin : g_reg
            assign mem_if.pipeMemReg  = out_q;
            assign mem_if.memRegValid = valid_q;
            assign mem_if.memFault    = fault_q;
        end else begin : g_comb
            assign mem_if.pipeMemReg  = out_d;
            assign mem_if.memRegValid = valid_d;
            assign mem_if.memFault    = fault_d;
        end
    endgenerate

endmodule

// File: tb/tb_mips_stage_mem_multicycle.sv
// Directed bench for the multicycle memory stage at latencies 1, 3 and 4.
// Expected values are hand-computed constants.
module tb_mips_stage_mem_multicycle;
    import mips_stage_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_ab = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_stage_mem_multicycle_if if1 ();
    mips_stage_mem_multicycle_if if3 ();
    mips_stage_mem_multicycle_if if4 ();

    mips_stage_mem_multicycle #(.MEM_LATENCY(1)) u1 (
        .clock (clk),
        .reset (rst),
        .mem_if(if1)
    );
    mips_stage_mem_multicycle #(.MEM_LATENCY(3)) u3 (
        .clock (clk),
        .reset (rst),
        .mem_if(if3)
    );
    mips_stage_mem_multicycle #(.MEM_LATENCY(4)) u4 (
        .clock (clk),
        .reset (rst | rst_ab),
        .mem_if(if4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic Mips_Pipeline_ExMem_T mk(
        input logic rd, input logic wr, input logic [1:0] sz,
        input logic sg, input logic [31:0] a, input logic [31:0] d);
        Mips_Pipeline_ExMem_T e;
        e = '0;
        e.instruction = {16'h8c00, a[15:0]};
        e.pcAddr = 32'h0040_0000 + a;
        e.control.regWrite = ~wr;
        e.control.memToReg = rd;
        e.control.memRead = rd;
        e.control.memWrite = wr;
        e.control.memSize = sz;
        e.control.memSigned = sg;
        e.regPort2 = d;
        e.aluResult = a;
        return e;
    endfunction

    task automatic op1(input Mips_Pipeline_ExMem_T e,
                       output Mips_Pipeline_MemReg_T r,
                       output logic v, output logic f);
        if1.pipeExMem = e;
        if1.exMemValid = 1'b1;
        #1 check("l1_stall", {31'd0, if1.memStall}, 32'd0);
        @(posedge clk);
        #1;
        if1.exMemValid = 1'b0;
        r = if1.pipeMemReg;
        v = if1.memRegValid;
        f = if1.memFault;
    endtask

    task automatic op3(input Mips_Pipeline_ExMem_T e,
                       output Mips_Pipeline_MemReg_T r, output logic v);
        if3.pipeExMem = e;
        if3.exMemValid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 check("l3_stall", {31'd0, if3.memStall}, {31'd0, c < 2});
            if (c > 0) check("l3_early", {31'd0, if3.memRegValid}, 32'd0);
            @(posedge clk);
            #1;
        end
        if3.exMemValid = 1'b0;
        r = if3.pipeMemReg;
        v = if3.memRegValid;
    endtask

    task automatic op4(input Mips_Pipeline_ExMem_T e,
                       output Mips_Pipeline_MemReg_T r, output logic v);
        if4.pipeExMem = e;
        if4.exMemValid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 check("l4_stall", {31'd0, if4.memStall}, {31'd0, c < 3});
            if (c > 0) check("l4_early", {31'd0, if4.memRegValid}, 32'd0);
            @(posedge clk);
            #1;
        end
        if4.exMemValid = 1'b0;
        r = if4.pipeMemReg;
        v = if4.memRegValid;
    endtask

    Mips_Pipeline_MemReg_T r;
    logic v;
    logic f;

    initial begin
        if1.exMemValid = 1'b0;
        if3.exMemValid = 1'b0;
        if4.exMemValid = 1'b0;
        if1.pipeExMem = '0;
        if3.pipeExMem = '0;
        if4.pipeExMem = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid1", {31'd0, if1.memRegValid}, 32'd0);
        check("rst_stall1", {31'd0, if1.memStall}, 32'd0);
        check("rst_fault1", {31'd0, if1.memFault}, 32'd0);
        check("rst_out1", if1.pipeMemReg.memOut, 32'd0);
        check("rst_valid3", {31'd0, if3.memRegValid}, 32'd0);
        check("rst_valid4", {31'd0, if4.memRegValid}, 32'd0);
        rst = 1'b0;

        op1(mk(0, 1, 2, 0, 32'h10, 32'hDEADBEEF), r, v, f);
        check("sw_valid", {31'd0, v}, 32'd1);
        check("sw_out", r.memOut, 32'd0);
        op1(mk(1, 0, 2, 0, 32'h10, 32'h0), r, v, f);
        check("lw_valid", {31'd0, v}, 32'd1);
        check("lw_out", r.memOut, 32'hDEADBEEF);
        check("lw_alu", r.aluResult, 32'h10);
        check("lw_pc", r.pcAddr, 32'h0040_0010);
        @(posedge clk);
        #1 check("bubble", {31'd0, if1.memRegValid}, 32'd0);

        op1(mk(0, 1, 2, 0, 32'h20, 32'h11223344), r, v, f);
        op1(mk(0, 1, 0, 0, 32'h21, 32'h00000080), r, v, f);
        op1(mk(1, 0, 0, 1, 32'h21, 32'h0), r, v, f);
        check("lb_s", r.memOut, 32'hFFFFFF80);
        op1(mk(1, 0, 0, 0, 32'h21, 32'h0), r, v, f);
        check("lb_u", r.memOut, 32'h00000080);
        op1(mk(1, 0, 2, 0, 32'h20, 32'h0), r, v, f);
        check("sb_word", r.memOut, 32'h11228044);

        op1(mk(0, 1, 2, 0, 32'h104, 32'hCAFEF00D), r, v, f);
        op1(mk(1, 0, 2, 0, 32'h004, 32'h0), r, v, f);
        check("wrap", r.memOut, 32'hCAFEF00D);

        op1(mk(1, 1, 2, 0, 32'h30, 32'h0BADF00D), r, v, f);
        check("rdwr_out", r.memOut, 32'd0);
        op1(mk(0, 1, 1, 0, 32'h32, 32'h0000BEEF), r, v, f);
        op1(mk(1, 0, 2, 0, 32'h30, 32'h0), r, v, f);
        check("sh_word", r.memOut, 32'hBEEFF00D);

        op1(mk(0, 0, 0, 0, 32'h55, 32'h0), r, v, f);
        check("alu_valid", {31'd0, v}, 32'd1);
        check("alu_out", r.memOut, 32'd0);
        check("alu_res", r.aluResult, 32'h55);

        op1(mk(1, 0, 1, 1, 32'h13, 32'h0), r, v, f);
`ifdef MIPS_STAGE_MEM_ALIGN_CHECK_EN
        check("mis_fault", {31'd0, f}, 32'd1);
        check("mis_out", r.memOut, 32'd0);
        check("mis_rw", {31'd0, r.control.regWrite}, 32'd0);
`else
        check("mis_fault", {31'd0, f}, 32'd0);
        check("mis_out", r.memOut, 32'hFFFFDEAD);
        check("mis_rw", {31'd0, r.control.regWrite}, 32'd1);
`endif

        op3(mk(0, 1, 2, 0, 32'h40, 32'h13579BDF), r, v);
        check("l3_sw_valid", {31'd0, v}, 32'd1);
        op3(mk(1, 0, 2, 0, 32'h40, 32'h0), r, v);
        check("l3_lw_valid", {31'd0, v}, 32'd1);
        check("l3_lw_out", r.memOut, 32'h13579BDF);
        if3.pipeExMem = mk(0, 0, 0, 0, 32'h77, 32'h0);
        if3.exMemValid = 1'b1;
        #1 check("l3_add_stall", {31'd0, if3.memStall}, 32'd0);
        @(posedge clk);
        #1;
        if3.exMemValid = 1'b0;
        check("l3_add_valid", {31'd0, if3.memRegValid}, 32'd1);
        check("l3_add_alu", if3.pipeMemReg.aluResult, 32'h77);
        @(posedge clk);
        #1 check("l3_add_once", {31'd0, if3.memRegValid}, 32'd0);

        op4(mk(0, 1, 2, 0, 32'h08, 32'h0A0B0C0D), r, v);
        check("l4_sw_valid", {31'd0, v}, 32'd1);
        if4.pipeExMem = mk(0, 1, 2, 0, 32'h08, 32'hFFFFFFFF);
        if4.exMemValid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 check("l4_busy2_stall", {31'd0, if4.memStall}, 32'd1);
        rst_ab = 1'b1;
        if4.exMemValid = 1'b0;
        @(posedge clk);
        #1;
        rst_ab = 1'b0;
        check("l4_rst_valid", {31'd0, if4.memRegValid}, 32'd0);
        check("l4_rst_stall", {31'd0, if4.memStall}, 32'd0);
        check("l4_rst_out", if4.pipeMemReg.memOut, 32'd0);
        check("l4_rst_instr", if4.pipeMemReg.instruction, 32'd0);
        op4(mk(1, 0, 2, 0, 32'h08, 32'h0), r, v);
        check("l4_lw_valid", {31'd0, v}, 32'd1);
        check("l4_lw_out", r.memOut, 32'h0A0B0C0D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
